// File: rtl/vid_line_fetch_sched.sv
// vid_line_fetch_sched: one burst read per active video line, prefetched ahead of display.
// Optional build macro: FB_PINGPONG_EN (alternate fb_base/fb_base1 on successive frames).
// Ports: video_clk/rst_n (async, active-low) clock and reset; enable scheduler enable;
//   fb_base/fb_base1 frame buffer bases; vs/de timing inputs; rd_req/rd_addr/rd_len/rd_ack
//   read request handshake; rd_done line-landed pulse; frame_start pulse; underflow sticky
//   flag with underflow_clr; busy when not idle.
module vid_line_fetch_sched #(
    parameter int          H_ACTIVE       = 1280,
    parameter int          V_ACTIVE       = 720,
    parameter int          BPP_BYTES      = 2,
    parameter logic [31:0] LINE_STRIDE    = 32'd2560,
    parameter int          PREFETCH_LINES = 2,
    parameter logic        VS_POL         = 1'b1
) (
    input  logic        video_clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] fb_base,
    input  logic [31:0] fb_base1,
    input  logic        vs,
    input  logic        de,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    output logic [15:0] rd_len,
    input  logic        rd_ack,
    input  logic        rd_done,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr,
    output logic        busy
);

    localparam int CW = $clog2(V_ACTIVE + 1);
    localparam logic [CW-1:0] V_MAX  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] PF_CNT = CW'(PREFETCH_LINES);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] ZERO   = '0;
    localparam logic [15:0]   RD_LEN = 16'(H_ACTIVE * BPP_BYTES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    logic          vs_q;
    logic          de_q;
    logic          restart;
    logic [CW-1:0] issued;
    logic [CW-1:0] credits;
    logic [CW-1:0] ready;
    logic [CW-1:0] credits_nxt;
    logic [CW-1:0] ready_nxt;
    logic [31:0]   base_sel;
    logic          vs_rise;
    logic          de_rise;
    logic          de_fall;
    logic          ack_hit;
    logic          fs_go;
    logic          credit_add;
    logic          uf_set;

    assign rd_len  = RD_LEN;
    assign vs_rise = (vs == VS_POL) && (vs_q != VS_POL);
    assign de_rise = de && !de_q;
    assign de_fall = !de && de_q;
    assign ack_hit = (state == ISSUE) && rd_ack;

    // A vs edge during a request is held in restart and taken on the ack.
    assign fs_go = enable &&
                   ((vs_rise && (state != ISSUE)) ||
                    (ack_hit && (restart || vs_rise)));

    // Grant a line only while granted + outstanding stays within the frame.
    assign credit_add = de_fall &&
                        (({1'b0, issued} + {1'b0, credits}) < {1'b0, V_MAX});

    assign credits_nxt = credits + (credit_add ? ONE : ZERO)
                                 - (ack_hit ? ONE : ZERO);

    always_comb begin
        ready_nxt = ready;
        uf_set    = 1'b0;
        if (rd_done && !de_rise) begin
            if (ready != V_MAX)
                ready_nxt = ready + ONE;
        end else if (de_rise && !rd_done) begin
            if (ready == ZERO)
                uf_set = 1'b1;
            else
                ready_nxt = ready - ONE;
        end
    end

`ifdef FB_PINGPONG_EN
    logic buf_sel;

    assign base_sel = buf_sel ? fb_base1 : fb_base;

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n)
            buf_sel <= 1'b0;
        else if (fs_go)
            buf_sel <= ~buf_sel;
    end
`else
    logic unused_fb_base1;

    assign base_sel        = fb_base;
    assign unused_fb_base1 = ^fb_base1;
`endif

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            restart     <= 1'b0;
            issued      <= ZERO;
            credits     <= ZERO;
            ready       <= ZERO;
            rd_req      <= 1'b0;
            rd_addr     <= 32'd0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            vs_q        <= vs;
            de_q        <= de;
            frame_start <= 1'b0;

            if (uf_set)
                underflow <= 1'b1;
            else if (underflow_clr)
                underflow <= 1'b0;

            if (fs_go) begin
                frame_start <= 1'b1;
                rd_addr     <= base_sel;
                issued      <= ZERO;
                credits     <= PF_CNT;
                ready       <= ZERO;
                restart     <= 1'b0;
            end else begin
                credits <= credits_nxt;
                ready   <= ready_nxt;
                if (ack_hit) begin
                    issued  <= issued + ONE;
                    rd_addr <= rd_addr + LINE_STRIDE;
                end
            end

            unique case (state)
                IDLE: begin
                    if (fs_go) begin
                        state  <= ISSUE;
                        rd_req <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (vs_rise && !ack_hit)
                        restart <= 1'b1;
                    if (ack_hit) begin
                        rd_req <= 1'b0;
                        if (!enable) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            restart <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (fs_go) begin
                        state  <= ISSUE;
                        rd_req <= 1'b1;
                    end else if (credits != ZERO && issued < V_MAX) begin
                        state  <= ISSUE;
                        rd_req <= 1'b1;
                    end else if (issued == V_MAX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (fs_go) begin
                        state  <= ISSUE;
                        rd_req <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
